aes128_word_io: RTL and testbench

- Sequential wrapper stage directly upstream and downstream of the combinational aes128 / aes128_1 cores.
- Upstream side: packs a 32-bit word stream into a 128-bit key register and a 128-bit block register, then presents both to the core, with a mode select for encrypt or decrypt.
- Downstream side: waits a fixed settle time, captures the core result, and serialises it back out as four 32-bit words.
- All handshakes are valid/ready.

---
 rtl/aes128_word_io.sv | 167 ++++++++++++++++
 tb/tb_aes128_word_io.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes128_word_io.sv
// aes128_word_io: packs 32-bit words into key/block for the aes128 cores and serialises the result; CORE_LAT cycles from 4th data word to out_valid.
// in_ready drops during WAIT/OUT, out side holds indefinitely under backpressure; AES_BLK_CNT_EN adds the blk_cnt output.
module aes128_word_io #(
  parameter int CORE_LAT = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [31:0]  in_data,
  input  logic         in_key,
  input  logic         in_mode,
  output logic [127:0] core_in,
  output logic [127:0] core_k,
  output logic         core_mode,
  input  logic [127:0] core_out,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [31:0]  out_data,
  output logic         key_ok,
`ifdef AES_BLK_CNT_EN
  output logic         err,
  output logic [15:0]  blk_cnt
`else
  output logic         err
`endif
);

  typedef enum logic [1:0] {ST_LOAD, ST_WAIT, ST_OUT} state_t;

  localparam logic [3:0] WCNT_LAST = 4'(CORE_LAT - 1);

  state_t       state_q, state_d;
  logic [1:0]   kcnt_q, kcnt_d;
  logic [1:0]   dcnt_q, dcnt_d;
  logic [1:0]   ocnt_q, ocnt_d;
  logic [3:0]   wcnt_q, wcnt_d;
  logic [127:0] core_in_q, core_in_d;
  logic [127:0] core_k_q, core_k_d;
  logic [127:0] obuf_q, obuf_d;
  logic         core_mode_q, core_mode_d;
  logic         out_valid_q, out_valid_d;
  logic         key_ok_q, key_ok_d;
  logic         err_q, err_d;
  logic         in_xfer, out_xfer, last_xfer;

  assign in_ready  = (state_q == ST_LOAD);
  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = out_valid_q && out_ready;
  assign last_xfer = out_xfer && (ocnt_q == 2'd3);

  assign core_in   = core_in_q;
  assign core_k    = core_k_q;
  assign core_mode = core_mode_q;
  assign out_valid = out_valid_q;
  assign out_data  = obuf_q[127:96];
  assign key_ok    = key_ok_q;
  assign err       = err_q;

  always_comb begin
    state_d     = state_q;
    kcnt_d      = kcnt_q;
    dcnt_d      = dcnt_q;
    ocnt_d      = ocnt_q;
    wcnt_d      = wcnt_q;
    core_in_d   = core_in_q;
    core_k_d    = core_k_q;
    obuf_d      = obuf_q;
    core_mode_d = core_mode_q;
    out_valid_d = out_valid_q;
    key_ok_d    = key_ok_q;
    err_d       = err_q;
    case (state_q)
      ST_LOAD: begin
        if (in_xfer) begin
          if (in_key) begin
            // Slot index ~cnt puts word 0 at [127:96]; a new key invalidates the old one immediately.
            core_k_d[{~kcnt_q, 5'b0} +: 32] = in_data;
            kcnt_d = kcnt_q + 2'd1;
            if (kcnt_q == 2'd3) key_ok_d = 1'b1;
            else if (kcnt_q == 2'd0) key_ok_d = 1'b0;
          end else if (key_ok_q) begin
            core_in_d[{~dcnt_q, 5'b0} +: 32] = in_data;
            dcnt_d = dcnt_q + 2'd1;
            if (dcnt_q == 2'd3) begin
              core_mode_d = in_mode;
              wcnt_d      = 4'd0;
              state_d     = ST_WAIT;
            end
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        wcnt_d = wcnt_q + 4'd1;
        if (wcnt_q == WCNT_LAST) begin
          obuf_d      = core_out;
          out_valid_d = 1'b1;
          ocnt_d      = 2'd0;
          state_d     = ST_OUT;
        end
      end
      ST_OUT: begin
        if (out_xfer) begin
          obuf_d = {obuf_q[95:0], 32'h0};
          ocnt_d = ocnt_q + 2'd1;
          if (ocnt_q == 2'd3) begin
            out_valid_d = 1'b0;
            state_d     = ST_LOAD;
          end
        end
      end
      default: state_d = ST_LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_LOAD;
      kcnt_q      <= 2'd0;
      dcnt_q      <= 2'd0;
      ocnt_q      <= 2'd0;
      wcnt_q      <= 4'd0;
      core_in_q   <= 128'h0;
      core_k_q    <= 128'h0;
      obuf_q      <= 128'h0;
      core_mode_q <= 1'b0;
      out_valid_q <= 1'b0;
      key_ok_q    <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      kcnt_q      <= kcnt_d;
      dcnt_q      <= dcnt_d;
      ocnt_q      <= ocnt_d;
      wcnt_q      <= wcnt_d;
      core_in_q   <= core_in_d;
      core_k_q    <= core_k_d;
      obuf_q      <= obuf_d;
      core_mode_q <= core_mode_d;
      out_valid_q <= out_valid_d;
      key_ok_q    <= key_ok_d;
      err_q       <= err_d;
    end
  end

`ifdef AES_BLK_CNT_EN
  logic [15:0] blk_cnt_q, blk_cnt_d;

  always_comb begin
    blk_cnt_d = blk_cnt_q;
    if (last_xfer) blk_cnt_d = blk_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) blk_cnt_q <= 16'd0;
    else        blk_cnt_q <= blk_cnt_d;
  end

  assign blk_cnt = blk_cnt_q;
`else
  logic last_xfer_unused;
  assign last_xfer_unused = last_xfer;
`endif

endmodule

// File: tb/tb_aes128_word_io.sv
// Bench for aes128_word_io with a behavioural stand-in for the aes128/aes128_1 cores and a queue scoreboard.
module tb_aes128_word_io;
  localparam int CORE_LAT = 2;
  localparam logic [127:0] FK = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FP = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FC = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] K2 = 128'hdeadbeef0123456789abcdeffedcba98;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [31:0]  in_data = 32'h0;
  logic         in_key = 1'b0;
  logic         in_mode = 1'b0;
  logic [127:0] core_in, core_k, core_out;
  logic         core_mode;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [31:0]  out_data;
  logic         key_ok, err;
`ifdef AES_BLK_CNT_EN
  logic [15:0]  blk_cnt;
`endif

  int checks = 0;
  int errors = 0;
  logic [31:0]  sb[$];
  logic [127:0] bkey = 128'h0;

  aes128_word_io #(.CORE_LAT(CORE_LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_key(in_key), .in_mode(in_mode),
    .core_in(core_in), .core_k(core_k), .core_mode(core_mode), .core_out(core_out),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .key_ok(key_ok),
`ifdef AES_BLK_CNT_EN
    .err(err), .blk_cnt(blk_cnt)
`else
    .err(err)
`endif
  );

  always #5 clk = ~clk;

  // Stand-in core: FIPS-197 vector pair exactly, an arbitrary keyed mix otherwise.
  function automatic logic [127:0] core_model(input logic [127:0] blk, input logic [127:0] k,
                                              input logic m);
    if (!m && k == FK && blk == FP) return FC;
    if (m && k == FK && blk == FC) return FP;
    if (!m) return {blk[95:0], blk[127:96]} ^ k;
    return blk ^ ~k;
  endfunction

  assign core_out = core_model(core_in, core_k, core_mode);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    sb.delete();
    bkey = 128'h0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic send_word(input logic [31:0] d, input logic key, input logic mode);
    int n;
    in_valid = 1'b1; in_data = d; in_key = key; in_mode = mode;
    n = 0;
    while (in_ready !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL send_word_ready: in_ready=%b required 1 within 50 cycles", in_ready);
    end else begin
      tick();
    end
    in_valid = 1'b0; in_key = 1'b0; in_mode = 1'b0;
  endtask

  task automatic load_key(input logic [127:0] k);
    for (int i = 0; i < 4; i++) send_word(k[127-32*i -: 32], 1'b1, 1'b0);
    bkey = k;
  endtask

  // Sends data words first..3, pushes the expected words, then checks the WAIT latency.
  task automatic send_block(input logic [127:0] blk, input logic mode, input int first);
    logic [127:0] exp;
    int n;
    for (int i = first; i < 4; i++) send_word(blk[127-32*i -: 32], 1'b0, (i == 3) ? mode : ~mode);
    exp = core_model(blk, bkey, mode);
    for (int i = 0; i < 4; i++) sb.push_back(exp[127-32*i -: 32]);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL wait_entry: out_valid=%b in_ready=%b required 0 0", out_valid, in_ready);
    end
    n = 0;
    do begin
      tick();
      n++;
    end while (out_valid !== 1'b1 && n < 20);
    checks++;
    if (out_valid !== 1'b1 || n != CORE_LAT) begin
      errors++;
      $display("FAIL latency: out_valid=%b after %0d cycles, required 1 after %0d", out_valid, n, CORE_LAT);
    end
  endtask

  task automatic drain(input int gap);
    logic [31:0] first, exp;
    for (int w = 0; w < 4; w++) begin
      if (gap > 0) begin
        out_ready = 1'b0;
        first = out_data;
        repeat (gap) begin
          tick();
          checks++;
          if (out_valid !== 1'b1 || out_data !== first || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL hold_w%0d: valid=%b data=%h in_ready=%b required 1 %h 0",
                     w, out_valid, out_data, in_ready, first);
          end
        end
      end
      out_ready = 1'b1;
      exp = (sb.size() > 0) ? sb.pop_front() : 32'hxxxxxxxx;
      checks++;
      if (out_valid !== 1'b1 || out_data !== exp || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL out_word%0d: valid=%b data=%h in_ready=%b required 1 %h 0",
                 w, out_valid, out_data, in_ready, exp);
      end
      tick();
      out_ready = 1'b0;
    end
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reassert: in_ready=%b out_valid=%b required 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    checks++;
    if ({core_in, core_k, core_mode, out_data, out_valid, key_ok, err} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: core_in=%h core_k=%h mode=%b out=%h ov=%b key_ok=%b err=%b required all 0",
               core_in, core_k, core_mode, out_data, out_valid, key_ok, err);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_encrypt();
    send_word(FK[127:96], 1'b1, 1'b0);
    send_word(FK[95:64], 1'b1, 1'b0);
    send_word(FK[63:32], 1'b1, 1'b0);
    checks++;
    if (key_ok !== 1'b0) begin
      errors++;
      $display("FAIL key_ok_partial: key_ok=%b required 0", key_ok);
    end
    send_word(FK[31:0], 1'b1, 1'b0);
    bkey = FK;
    checks++;
    if (key_ok !== 1'b1 || core_k !== FK) begin
      errors++;
      $display("FAIL key_load: key_ok=%b core_k=%h required 1 %h", key_ok, core_k, FK);
    end
    send_block(FP, 1'b0, 0);
    checks++;
    if (core_in !== FP || core_mode !== 1'b0) begin
      errors++;
      $display("FAIL enc_core_in: core_in=%h mode=%b required %h 0", core_in, core_mode, FP);
    end
    drain(0);
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL enc_err: err=%b required 0", err);
    end
  endtask

  task automatic test_decrypt();
    send_block(FC, 1'b1, 0);
    checks++;
    if (core_mode !== 1'b1 || core_k !== FK) begin
      errors++;
      $display("FAIL dec_mode: core_mode=%b core_k=%h required 1 %h", core_mode, core_k, FK);
    end
    drain(0);
  endtask

  task automatic test_backpressure();
    send_block(FP, 1'b0, 0);
    drain(7);
  endtask

  task automatic test_mixed();
    logic [127:0] blk;
    blk = 128'hcafef00d11112222333344445555aaaa;
    send_word(blk[127:96], 1'b0, 1'b0);
    send_word(blk[95:64], 1'b0, 1'b0);
    send_word(K2[127:96], 1'b1, 1'b0);
    checks++;
    if (key_ok !== 1'b0) begin
      errors++;
      $display("FAIL reload_start: key_ok=%b required 0", key_ok);
    end
    send_word(K2[95:64], 1'b1, 1'b0);
    send_word(K2[63:32], 1'b1, 1'b0);
    send_word(K2[31:0], 1'b1, 1'b0);
    bkey = K2;
    checks++;
    if (key_ok !== 1'b1 || err !== 1'b0) begin
      errors++;
      $display("FAIL reload_done: key_ok=%b err=%b required 1 0", key_ok, err);
    end
    send_block(blk, 1'b0, 2);
    drain(0);
  endtask

  task automatic test_no_key();
    int seen;
    do_reset();
    send_word(32'h12345678, 1'b0, 1'b0);
    checks++;
    if (err !== 1'b1 || key_ok !== 1'b0) begin
      errors++;
      $display("FAIL nokey_err: err=%b key_ok=%b required 1 0", err, key_ok);
    end
    seen = 0;
    repeat (CORE_LAT + 4) begin
      if (out_valid !== 1'b0) seen++;
      tick();
    end
    checks++;
    if (seen != 0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL nokey_quiet: out_valid cycles=%0d in_ready=%b required 0 1", seen, in_ready);
    end
    load_key(FK);
    send_block(FP, 1'b0, 0);
    drain(0);
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $display("FAIL err_sticky: err=%b required 1", err);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    load_key(FK);
    for (int i = 0; i < 4; i++) send_word(FP[127-32*i -: 32], 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({core_in, core_k, core_mode, out_data, out_valid, key_ok, err} !== '0) begin
      errors++;
      $display("FAIL reset_mid: core_in=%h core_k=%h mode=%b out=%h ov=%b key_ok=%b err=%b required all 0",
               core_in, core_k, core_mode, out_data, out_valid, key_ok, err);
    end
    sb.delete();
    tick();
    rst_n = 1'b1;
    tick();
    send_word(FP[127:96], 1'b0, 1'b0);
    checks++;
    if (err !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_needs_key: err=%b out_valid=%b required 1 0", err, out_valid);
    end
    load_key(FK);
    send_block(FP, 1'b0, 0);
    drain(0);
  endtask

`ifdef AES_BLK_CNT_EN
  task automatic test_blk_cnt();
    do_reset();
    checks++;
    if (blk_cnt !== 16'd0) begin
      errors++;
      $display("FAIL blk_cnt_reset: blk_cnt=%0d required 0", blk_cnt);
    end
    load_key(FK);
    for (int b = 0; b < 3; b++) begin
      send_block(FP ^ 128'(b), 1'b0, 0);
      drain(0);
    end
    checks++;
    if (blk_cnt !== 16'd3) begin
      errors++;
      $display("FAIL blk_cnt: blk_cnt=%0d required 3", blk_cnt);
    end
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_encrypt();
    test_decrypt();
    test_backpressure();
    test_mixed();
    test_no_key();
    test_reset_mid();
`ifdef AES_BLK_CNT_EN
    test_blk_cnt();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
